// File: rtl/disk_xfer_ctrl.sv
// Disk transfer controller: moves 16-bit word blocks between a disk port and
// the RAM transfer port, with a per-word acknowledge timeout.
module disk_xfer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] mem_base,
  input  logic [ADDR_WIDTH-1:0] disk_base,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] words_done,
  output logic                  ldd,
  output logic                  tr,
  output logic [ADDR_WIDTH-1:0] addr_t,
  output logic [DATA_WIDTH-1:0] data_t,
  input  logic [DATA_WIDTH-1:0] q_t,
  output logic                  disk_req,
  output logic                  disk_we,
  output logic [ADDR_WIDTH-1:0] disk_addr,
  output logic [DATA_WIDTH-1:0] disk_wdata,
  input  logic [DATA_WIDTH-1:0] disk_rdata,
  input  logic                  disk_ack
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LREQ   = 3'd1;
  localparam logic [2:0] S_LWR    = 3'd2;
  localparam logic [2:0] S_SFETCH = 3'd3;
  localparam logic [2:0] S_SREQ   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // The wait counter only needs to reach TIMEOUT-1: the last waiting cycle exits.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_mem_ptr;
  logic [ADDR_WIDTH-1:0] r_disk_ptr;
  logic [ADDR_WIDTH-1:0] r_remain;
  logic [ADDR_WIDTH-1:0] r_words;
  logic [DATA_WIDTH-1:0] r_data;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_err;
  logic                  w_last_word;

  assign w_last_word = (r_remain == ADDR_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_ptr  <= '0;
      r_disk_ptr <= '0;
      r_remain   <= '0;
      r_words    <= '0;
      r_data     <= '0;
      r_wait     <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err   <= 1'b0;
            r_words <= '0;
            if (len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_mem_ptr  <= mem_base;
              r_disk_ptr <= disk_base;
              r_remain   <= len;
              r_wait     <= '0;
              r_state    <= dir ? S_SFETCH : S_LREQ;
            end
          end
        end
        S_LREQ: begin
          if (disk_ack) begin
            r_data  <= disk_rdata;
            r_state <= S_LWR;
          end else if (r_wait == WAIT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_LWR: begin
          r_mem_ptr  <= r_mem_ptr + ADDR_WIDTH'(1);
          r_disk_ptr <= r_disk_ptr + ADDR_WIDTH'(1);
          r_words    <= r_words + ADDR_WIDTH'(1);
          r_remain   <= r_remain - ADDR_WIDTH'(1);
          r_wait     <= '0;
          r_state    <= w_last_word ? S_DONE : S_LREQ;
        end
        S_SFETCH: begin
          r_data  <= q_t;
          r_wait  <= '0;
          r_state <= S_SREQ;
        end
        S_SREQ: begin
          // An ack in the final waiting cycle takes priority over the timeout.
          if (disk_ack) begin
            r_mem_ptr  <= r_mem_ptr + ADDR_WIDTH'(1);
            r_disk_ptr <= r_disk_ptr + ADDR_WIDTH'(1);
            r_words    <= r_words + ADDR_WIDTH'(1);
            r_remain   <= r_remain - ADDR_WIDTH'(1);
            r_state    <= w_last_word ? S_DONE : S_SFETCH;
          end else if (r_wait == WAIT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DONE, S_ERR: r_state <= S_IDLE;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_LREQ) || (r_state == S_LWR) ||
                      (r_state == S_SFETCH) || (r_state == S_SREQ);
  assign ldd        = busy;
  assign done       = (r_state == S_DONE) || (r_state == S_ERR);
  assign tr         = (r_state == S_LWR);
  assign disk_req   = (r_state == S_LREQ) || (r_state == S_SREQ);
  assign disk_we    = (r_state == S_SREQ);
  assign err        = r_err;
  assign words_done = r_words;
  assign addr_t     = r_mem_ptr;
  assign data_t     = r_data;
  assign disk_addr  = r_disk_ptr;
  assign disk_wdata = r_data;

endmodule

// File: tb/tb_disk_xfer_ctrl.sv
// Directed bench for disk_xfer_ctrl with behavioural RAM and disk models.
module tb_disk_xfer_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] mem_base = '0, disk_base = '0, len = '0;
  logic          busy, done, err, ldd, tr, disk_req, disk_we, disk_ack;
  logic [AW-1:0] words_done, addr_t, disk_addr;
  logic [DW-1:0] data_t, q_t, disk_wdata, disk_rdata;

  always #5 clk = ~clk;

  disk_xfer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .mem_base(mem_base),
    .disk_base(disk_base), .len(len), .busy(busy), .done(done), .err(err),
    .words_done(words_done), .ldd(ldd), .tr(tr), .addr_t(addr_t), .data_t(data_t),
    .q_t(q_t), .disk_req(disk_req), .disk_we(disk_we), .disk_addr(disk_addr),
    .disk_wdata(disk_wdata), .disk_rdata(disk_rdata), .disk_ack(disk_ack)
  );

  // RAM and disk models; preloads go through the same process that models writes.
  logic [DW-1:0] ram [0:65535];
  logic [DW-1:0] dsk [0:65535];
  logic          pl_ram_we = 1'b0, pl_dsk_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  int            ack_delay = 1;
  int            block_idx = -1;
  int            ack_idx = 0;
  int            req_age = 0;

  assign q_t        = ram[addr_t];
  assign disk_rdata = dsk[disk_addr];
  assign disk_ack   = disk_req && (req_age >= ack_delay) && (ack_idx != block_idx);

  always @(posedge clk) begin
    if (pl_ram_we) ram[pl_addr] <= pl_data;
    else if (tr) ram[addr_t] <= data_t;
    if (pl_dsk_we) dsk[pl_addr] <= pl_data;
    else if (disk_req && disk_ack && disk_we) dsk[disk_addr] <= disk_wdata;
    if (start && !busy) ack_idx <= 0;
    else if (disk_req && disk_ack) ack_idx <= ack_idx + 1;
    if (!disk_req || disk_ack) req_age <= 0;
    else req_age <= req_age + 1;
  end

  // Activity monitor, sampled mid-cycle.
  int            done_n = 0, busy_n = 0, req_n = 0, viol_n = 0;
  logic [AW-1:0] tra_q[$];
  logic [DW-1:0] trd_q[$];
  logic [AW-1:0] dka_q[$];
  logic [DW-1:0] dkd_q[$];
  logic          dkw_q[$];

  always @(negedge clk) begin
    if (done) done_n <= done_n + 1;
    if (busy) busy_n <= busy_n + 1;
    if (disk_req) req_n <= req_n + 1;
    if ((tr && !ldd) || (ldd != busy) || (disk_req && !busy)) viol_n <= viol_n + 1;
    if (tr) begin
      tra_q.push_back(addr_t);
      trd_q.push_back(data_t);
    end
    if (disk_req && disk_ack) begin
      dka_q.push_back(disk_addr);
      dkd_q.push_back(disk_wdata);
      dkw_q.push_back(disk_we);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic pl_ram(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_ram_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_ram_we = 1'b0;
  endtask

  task automatic pl_dsk(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_dsk_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_dsk_we = 1'b0;
  endtask

  task automatic start_cmd(input logic d, input logic [AW-1:0] mb,
                           input logic [AW-1:0] db, input logic [AW-1:0] ln);
    start = 1'b1; dir = d; mem_base = mb; disk_base = db; len = ln;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts mid-cycle samples before done appears; returns one cycle after the pulse.
  task automatic wait_done(input string tag, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else cyc++;
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
  endtask

  int cyc, b_done, b_busy, b_req, b_tr, b_dk;

  task automatic snap();
    b_done = done_n; b_busy = busy_n; b_req = req_n;
    b_tr = tra_q.size(); b_dk = dka_q.size();
  endtask

  initial begin
    #23;
    check("reset_ctrl", {26'd0, busy, done, err, ldd, tr, disk_req}, 32'd0);
    check("reset_regs", {16'd0, words_done | addr_t | disk_addr | data_t | disk_wdata}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load, ack one cycle after request
    pl_dsk(16'h0100, 16'hA001); pl_dsk(16'h0101, 16'hA002); pl_dsk(16'h0102, 16'hA003);
    ack_delay = 1; block_idx = -1;
    snap();
    start_cmd(1'b0, 16'h0200, 16'h0100, 16'd3);
    wait_done("load", cyc);
    check("load_cycles", cyc, 9);
    check("load_busy_cycles", busy_n - b_busy, 9);
    check("load_ram0", ram[16'h0200], 16'hA001);
    check("load_ram1", ram[16'h0201], 16'hA002);
    check("load_ram2", ram[16'h0202], 16'hA003);
    check("load_tr_pulses", tra_q.size() - b_tr, 3);
    check("load_done_pulses", done_n - b_done, 1);
    check("load_words", words_done, 3);
    check("load_err", err, 0);

    // Store, same-cycle ack
    pl_ram(16'h0010, 16'h1111); pl_ram(16'h0011, 16'h2222);
    pl_ram(16'h0012, 16'h3333); pl_ram(16'h0013, 16'h4444);
    ack_delay = 0;
    snap();
    start_cmd(1'b1, 16'h0010, 16'h0300, 16'd4);
    wait_done("store", cyc);
    check("store_cycles", cyc, 8);
    check("store_disk_writes", dka_q.size() - b_dk, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("store_addr%0d", i), dka_q[b_dk + i], 32'h0300 + i);
      check($sformatf("store_data%0d", i), dkd_q[b_dk + i], 32'h1111 * (i + 1));
      check($sformatf("store_we%0d", i), dkw_q[b_dk + i], 1);
    end
    check("store_disk_mem3", dsk[16'h0303], 16'h4444);
    check("store_tr_none", tra_q.size() - b_tr, 0);
    check("store_words", words_done, 4);

    // Zero length
    snap();
    start_cmd(1'b0, 16'h0900, 16'h0900, 16'd0);
    wait_done("len0", cyc);
    check("len0_latency", cyc, 0);
    check("len0_req_cycles", req_n - b_req, 0);
    check("len0_tr_pulses", tra_q.size() - b_tr, 0);
    check("len0_busy_cycles", busy_n - b_busy, 0);
    check("len0_words", words_done, 0);

    // Address wrap-around
    pl_dsk(16'hFFFE, 16'hB001); pl_dsk(16'hFFFF, 16'hB002); pl_dsk(16'h0000, 16'hB003);
    ack_delay = 1;
    snap();
    start_cmd(1'b0, 16'hFFFF, 16'hFFFE, 16'd3);
    wait_done("wrap", cyc);
    check("wrap_tr_addr0", tra_q[b_tr + 0], 16'hFFFF);
    check("wrap_tr_addr1", tra_q[b_tr + 1], 16'h0000);
    check("wrap_tr_addr2", tra_q[b_tr + 2], 16'h0001);
    check("wrap_dk_addr0", dka_q[b_dk + 0], 16'hFFFE);
    check("wrap_dk_addr1", dka_q[b_dk + 1], 16'hFFFF);
    check("wrap_dk_addr2", dka_q[b_dk + 2], 16'h0000);
    check("wrap_ram_0000", ram[16'h0000], 16'hB002);
    check("wrap_ram_0001", ram[16'h0001], 16'hB003);
    check("wrap_err", err, 0);

    // Timeout on second word
    block_idx = 1;
    snap();
    start_cmd(1'b0, 16'h0500, 16'h0100, 16'd5);
    wait_done("tmo", cyc);
    check("tmo_cycles", cyc, 7);
    check("tmo_req_cycles", req_n - b_req, 6);
    check("tmo_err", err, 1);
    check("tmo_words", words_done, 1);
    check("tmo_done_pulses", done_n - b_done, 1);
    check("tmo_tr_pulses", tra_q.size() - b_tr, 1);
    block_idx = -1;
    start_cmd(1'b0, 16'h0800, 16'h0101, 16'd1);
    check("tmo_err_cleared", err, 0);
    wait_done("tmo_retry", cyc);
    check("tmo_retry_ram", ram[16'h0800], 16'hA002);
    check("tmo_retry_err", err, 0);

    // Ack in the last allowed waiting cycle completes the word
    ack_delay = TMO - 1;
    start_cmd(1'b0, 16'h0810, 16'h0102, 16'd1);
    wait_done("ackwin", cyc);
    check("ackwin_cycles", cyc, TMO + 1);
    check("ackwin_err", err, 0);
    check("ackwin_words", words_done, 1);
    check("ackwin_ram", ram[16'h0810], 16'hA003);

    // Reset during LREQ
    ack_delay = 1; block_idx = 0;
    start_cmd(1'b0, 16'h0700, 16'h0100, 16'd2);
    @(negedge clk); @(negedge clk);
    check("rst_pre_req", disk_req, 1);
    snap();
    #2 rst_n = 1'b0;
    #1 check("rst_outputs", {29'd0, disk_req, ldd, tr}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_done", done_n - b_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    block_idx = -1;
    @(posedge clk); #1;

    // Normal command after reset; a start while busy is ignored
    snap();
    start_cmd(1'b0, 16'h0600, 16'h0100, 16'd2);
    @(posedge clk); #1;
    start_cmd(1'b1, 16'h0010, 16'h0300, 16'd1);
    wait_done("post_rst", cyc);
    check("post_rst_ram0", ram[16'h0600], 16'hA001);
    check("post_rst_ram1", ram[16'h0601], 16'hA002);
    check("post_rst_words", words_done, 2);
    check("post_rst_done_pulses", done_n - b_done, 1);
    check("post_rst_disk_ops", dka_q.size() - b_dk, 2);
    check("post_rst_no_write", dkw_q[b_dk] | dkw_q[b_dk + 1], 0);

    check("port_rule_violations", viol_n, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
